// File: rtl/aggregation_fsm.sv
// Purpose: GCN aggregation controller; walks COO edges, accumulates FM_WM rows, streams result rows out.
// Latency: 1 (CLEAR) + 3 per edge + 1 per row written; done_agg rises one cycle after entering AGG_DONE.
// Backpressure: wr_valid/wr_addr held stable while wr_ready=0; each stalled cycle adds one cycle.
//
// Ports:
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   done_comb             level start request from the combination phase
//   coo_en/coo_addr       COO edge read; coo_row_in/coo_col_in return one cycle later
//   fm_wm_en/fm_wm_addr   FM_WM source-row read
//   acc_clear/acc_en/acc_row  accumulator control
//   wr_valid/wr_ready/wr_addr result-row write handshake (wr_addr also selects the accumulator row)
//   done_agg, edge_err, busy  status
module aggregation_fsm #(
  parameter int COO_NUM_OF_COLS     = 6,
  parameter int COO_BW              = 3,
  parameter int DOT_PROD_ROWS       = 6,
  parameter int DOT_PROD_ROWS_WIDTH = 3
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           done_comb,
  output logic                           coo_en,
  output logic [COO_BW-1:0]              coo_addr,
  input  logic [DOT_PROD_ROWS_WIDTH-1:0] coo_row_in,
  input  logic [DOT_PROD_ROWS_WIDTH-1:0] coo_col_in,
  output logic                           fm_wm_en,
  output logic [DOT_PROD_ROWS_WIDTH-1:0] fm_wm_addr,
  output logic                           acc_clear,
  output logic                           acc_en,
  output logic [DOT_PROD_ROWS_WIDTH-1:0] acc_row,
  output logic                           wr_valid,
  input  logic                           wr_ready,
  output logic [DOT_PROD_ROWS_WIDTH-1:0] wr_addr,
  output logic                           done_agg,
  output logic                           edge_err,
  output logic                           busy
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    CLEAR        = 3'd1,
    FETCH_EDGE   = 3'd2,
    LOOKUP       = 3'd3,
    ACCUM        = 3'd4,
    WRITE_RESULT = 3'd5,
    AGG_DONE     = 3'd6
  } state_t;

  localparam logic [COO_BW-1:0]              LAST_EDGE = COO_BW'(COO_NUM_OF_COLS - 1);
  localparam logic [DOT_PROD_ROWS_WIDTH-1:0] LAST_ROW  = DOT_PROD_ROWS_WIDTH'(DOT_PROD_ROWS - 1);

  state_t                         state, state_nxt;
  logic [COO_BW-1:0]              edge_cnt;
  logic [DOT_PROD_ROWS_WIDTH-1:0] row_cnt;
  logic [DOT_PROD_ROWS_WIDTH-1:0] dst_row;
  logic                           skip;
  logic                           edge_err_q;
  logic                           done_q;
  logic                           bad_edge;
  logic                           last_edge;
  logic                           last_row;

  // Zero-extend before comparing so a row index field wider than needed
  // (e.g. 7 with R=6) is caught rather than truncated.
  assign bad_edge  = (32'(coo_row_in) >= DOT_PROD_ROWS) || (32'(coo_col_in) >= DOT_PROD_ROWS);
  assign last_edge = (edge_cnt == LAST_EDGE);
  assign last_row  = (row_cnt == LAST_ROW);

  assign busy     = (state != IDLE) && (state != AGG_DONE);
  assign edge_err = edge_err_q;
  assign done_agg = done_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    coo_en     = 1'b0;
    coo_addr   = '0;
    fm_wm_en   = 1'b0;
    fm_wm_addr = '0;
    acc_clear  = 1'b0;
    acc_en     = 1'b0;
    acc_row    = '0;
    wr_valid   = 1'b0;
    wr_addr    = '0;
    case (state)
      IDLE: begin
        if (done_comb) state_nxt = CLEAR;
      end
      CLEAR: begin
        acc_clear = 1'b1;
        state_nxt = FETCH_EDGE;
      end
      FETCH_EDGE: begin
        coo_en    = 1'b1;
        coo_addr  = edge_cnt;
        state_nxt = LOOKUP;
      end
      LOOKUP: begin
        // COO data arrives this cycle; issue the FM_WM read straight from it
        // so the row is ready for ACCUM without an extra cycle.
        fm_wm_en   = !bad_edge;
        fm_wm_addr = coo_col_in;
        state_nxt  = ACCUM;
      end
      ACCUM: begin
        acc_en    = !skip;
        acc_row   = dst_row;
        state_nxt = last_edge ? WRITE_RESULT : FETCH_EDGE;
      end
      WRITE_RESULT: begin
        wr_valid = 1'b1;
        wr_addr  = row_cnt;
        if (wr_ready && last_row) state_nxt = AGG_DONE;
      end
      AGG_DONE: begin
        state_nxt = AGG_DONE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cnt   <= '0;
      row_cnt    <= '0;
      dst_row    <= '0;
      skip       <= 1'b0;
      edge_err_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (done_comb) begin
            edge_cnt <= '0;
            row_cnt  <= '0;
          end
        end
        LOOKUP: begin
          dst_row <= coo_row_in;
          skip    <= bad_edge;
          if (bad_edge) edge_err_q <= 1'b1;
        end
        ACCUM: begin
          skip <= 1'b0;
          if (!last_edge) edge_cnt <= edge_cnt + COO_BW'(1);
        end
        WRITE_RESULT: begin
          if (wr_ready && !last_row) row_cnt <= row_cnt + DOT_PROD_ROWS_WIDTH'(1);
        end
        AGG_DONE: begin
          done_q <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aggregation_fsm.sv
// Purpose: directed bench for aggregation_fsm with a 1-cycle COO memory model and a stalling result sink.
// Latency: measures edges from done_comb sample to done_agg against hand-computed values.
// Backpressure: the sink deasserts wr_ready for a programmed number of cycles at one row.
module tb_aggregation_fsm;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       done_comb = 1'b0;
  logic       coo_en;
  logic [2:0] coo_addr;
  logic [2:0] coo_row_in = '0;
  logic [2:0] coo_col_in = '0;
  logic       fm_wm_en;
  logic [2:0] fm_wm_addr;
  logic       acc_clear;
  logic       acc_en;
  logic [2:0] acc_row;
  logic       wr_valid;
  logic       wr_ready = 1'b1;
  logic [2:0] wr_addr;
  logic       done_agg;
  logic       edge_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  aggregation_fsm dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .done_comb  (done_comb),
    .coo_en     (coo_en),
    .coo_addr   (coo_addr),
    .coo_row_in (coo_row_in),
    .coo_col_in (coo_col_in),
    .fm_wm_en   (fm_wm_en),
    .fm_wm_addr (fm_wm_addr),
    .acc_clear  (acc_clear),
    .acc_en     (acc_en),
    .acc_row    (acc_row),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .done_agg   (done_agg),
    .edge_err   (edge_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // COO memory: one-cycle read latency.
  logic [2:0] mem_row [8];
  logic [2:0] mem_col [8];
  always @(posedge clk) begin
    if (coo_en) begin
      coo_row_in <= mem_row[coo_addr];
      coo_col_in <= mem_col[coo_addr];
    end
  end

  // Monitor and result sink, sampled on the falling edge.
  logic mon_clr = 1'b1;
  int   stall_row = -1;
  int   stall_n = 0;
  int   stall_used, hold_cnt;
  int   acc_cnt, fm_cnt, wr_cnt, clr_cnt, coo_cnt, busy_cnt;
  int   acc_rows [16];
  int   fm_addrs [16];
  int   wr_addrs [16];

  always @(negedge clk) begin
    if (mon_clr) begin
      stall_used = 0; hold_cnt = 0;
      acc_cnt = 0; fm_cnt = 0; wr_cnt = 0; clr_cnt = 0; coo_cnt = 0; busy_cnt = 0;
      wr_ready = 1'b1;
    end else begin
      if (wr_valid && int'(wr_addr) == stall_row) hold_cnt++;
      if (wr_valid && int'(wr_addr) == stall_row && stall_used < stall_n) begin
        wr_ready = 1'b0;
        stall_used++;
      end else begin
        wr_ready = 1'b1;
      end
      if (acc_en) begin
        if (acc_cnt < 16) acc_rows[acc_cnt] = int'(acc_row);
        acc_cnt++;
      end
      if (fm_wm_en) begin
        if (fm_cnt < 16) fm_addrs[fm_cnt] = int'(fm_wm_addr);
        fm_cnt++;
      end
      if (wr_valid && wr_ready) begin
        if (wr_cnt < 16) wr_addrs[wr_cnt] = int'(wr_addr);
        wr_cnt++;
      end
      if (acc_clear) clr_cnt++;
      if (coo_en) coo_cnt++;
      if (busy) busy_cnt++;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    done_comb = 1'b0;
    mon_clr = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    mon_clr = 1'b0;
  endtask

  task automatic load(input int r[6], input int c[6]);
    for (int i = 0; i < 6; i++) begin
      mem_row[i] = 3'(r[i]);
      mem_col[i] = 3'(c[i]);
    end
  endtask

  // Pulse done_comb for one sampling edge T and return edges from T until done_agg is seen.
  task automatic run(output int lat);
    @(negedge clk);
    done_comb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    done_comb = 1'b0;
    lat = 0;
    while (!done_agg && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_run(input string tag, input int lat, input int exp_lat, input int n_acc,
                           input int e_acc[6], input int e_fm[6], input int exp_err);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_acc_cnt"}, acc_cnt, n_acc);
    check({tag, "_fm_cnt"}, fm_cnt, n_acc);
    for (int i = 0; i < n_acc; i++) begin
      check($sformatf("%s_acc_row%0d", tag, i), acc_rows[i], e_acc[i]);
      check($sformatf("%s_fm_addr%0d", tag, i), fm_addrs[i], e_fm[i]);
    end
    check({tag, "_wr_cnt"}, wr_cnt, 6);
    for (int i = 0; i < 6; i++) check($sformatf("%s_wr_addr%0d", tag, i), wr_addrs[i], i);
    check({tag, "_clr_cnt"}, clr_cnt, 1);
    check({tag, "_coo_cnt"}, coo_cnt, 6);
    check({tag, "_edge_err"}, int'(edge_err), exp_err);
    check({tag, "_busy_end"}, int'(busy), 0);
  endtask

  function automatic int all_outs();
    return int'({coo_en, coo_addr, fm_wm_en, fm_wm_addr, acc_clear, acc_en, acc_row,
                 wr_valid, wr_addr, done_agg, edge_err, busy});
  endfunction

  int lat;
  int basic_r [6] = '{0, 1, 2, 3, 4, 5};
  int basic_c [6] = '{1, 0, 3, 2, 5, 4};
  int bad_r   [6] = '{0, 1, 2, 7, 4, 5};
  int bad_acc [6] = '{0, 1, 2, 4, 5, 0};
  int bad_fm  [6] = '{1, 0, 3, 5, 4, 0};
  int dup_r   [6] = '{2, 2, 2, 2, 2, 2};
  int dup_c   [6] = '{5, 5, 5, 5, 5, 5};

  initial begin
    for (int i = 0; i < 8; i++) begin
      mem_row[i] = '0;
      mem_col[i] = '0;
    end

    // Reset state.
    #1;
    check("reset_outputs", all_outs(), 0);
    do_reset();

    // Idle: no activity without done_comb.
    repeat (20) @(negedge clk);
    check("idle_strobes", acc_cnt + fm_cnt + wr_cnt + clr_cnt + coo_cnt, 0);
    check("idle_busy", busy_cnt, 0);

    // Basic run.
    load(basic_r, basic_c);
    run(lat);
    check_run("basic", lat, 26, 6, basic_r, basic_c, 0);

    // Re-trigger after completion is ignored.
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
    run(lat);
    repeat (10) @(negedge clk);
    check("retrig_done", int'(done_agg), 1);
    check("retrig_busy", busy_cnt, 0);
    check("retrig_strobes", acc_cnt + fm_cnt + wr_cnt + clr_cnt + coo_cnt, 0);

    // Backpressure at row 2 for 3 cycles.
    do_reset();
    stall_row = 2;
    stall_n = 3;
    run(lat);
    check_run("bp", lat, 29, 6, basic_r, basic_c, 0);
    check("bp_hold_cycles", hold_cnt, 4);
    stall_row = -1;
    stall_n = 0;

    // Out-of-range edge 3 is skipped and flagged.
    do_reset();
    load(bad_r, basic_c);
    run(lat);
    check_run("bad", lat, 26, 5, bad_acc, bad_fm, 1);
    repeat (3) @(negedge clk);
    check("bad_err_sticky", int'(edge_err), 1);

    // Duplicate edges accumulate every time.
    do_reset();
    load(dup_r, dup_c);
    run(lat);
    check_run("dup", lat, 26, 6, dup_r, dup_c, 0);

    // Reset during the ACCUM of edge 4, then a clean rerun.
    do_reset();
    load(basic_r, basic_c);
    @(negedge clk);
    done_comb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    done_comb = 1'b0;
    lat = 0;
    while (acc_cnt < 5 && lat < 100) begin
      @(negedge clk);
      #1;
      lat++;
    end
    check("midrst_reached_edge4", acc_cnt, 5);
    check("midrst_in_accum", int'(acc_en), 1);
    reset_n = 1'b0;
    #1;
    check("midrst_outputs", all_outs(), 0);
    do_reset();
    run(lat);
    check_run("rerun", lat, 26, 6, basic_r, basic_c, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
